// File: rtl/term_pkg.sv
// Shared types and character codes for the VGA terminal writer.
package term_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_e;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_DEL = 8'h7F;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_SP) && (ch < CH_DEL);
  endfunction

endpackage

// File: rtl/term_cursor.sv
// Text cursor: column, row and a running row base so the cell address
// never needs a multiplier. The cell address output is registered.
module term_cursor
  import term_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_col_i,
  input  logic              dec_col_i,
  input  logic              cr_i,
  input  logic              newline_i,
  input  logic              home_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] row_base_o,
  output logic              at_last_col_o,
  output logic              at_first_col_o
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Column and row move independently so a wrap can return and advance at once.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    if (home_i) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = '0;
    end else begin
      if (cr_i) begin
        col_d = '0;
      end else if (inc_col_i) begin
        col_d = col_q + 1'b1;
      end else if (dec_col_i) begin
        col_d = col_q - 1'b1;
      end
      if (newline_i) begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          row_d      = '0;
          row_base_d = '0;
        end else begin
          row_d      = row_q + 1'b1;
          row_base_d = row_base_q + ADDR_W'(COLS);
        end
      end
    end
    addr_d = row_base_d + ADDR_W'(col_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

  assign addr_o         = addr_q;
  assign row_base_o     = row_base_q;
  assign at_last_col_o  = (col_q == COL_W'(COLS - 1));
  assign at_first_col_o = (col_q == '0);

endmodule

// File: rtl/vga_term_writer.sv
// Terminal-style sequencer: turns a byte stream into VGA text-buffer writes,
// handling CR/LF/BS/FF and the line/screen clear sweeps.
module vga_term_writer
  import term_pkg::*;
#(
  parameter int         COLS   = 80,
  parameter int         ROWS   = 30,
  parameter int         ADDR_W = 14,
  parameter logic [7:0] FILL   = 8'h20
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] vga_waddr,
  output logic [7:0]        vga_wdata,
  output logic              vga_wr_en,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              inc_col, dec_col, cr, newline, home;
  logic [ADDR_W-1:0] cell_addr, row_base;
  logic              at_last_col, at_first_col;
  logic              accept;

  term_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk_i          (clk48),
    .rst_ni         (rst_n),
    .inc_col_i      (inc_col),
    .dec_col_i      (dec_col),
    .cr_i           (cr),
    .newline_i      (newline),
    .home_i         (home),
    .addr_o         (cell_addr),
    .row_base_o     (row_base),
    .at_last_col_o  (at_last_col),
    .at_first_col_o (at_first_col)
  );

  assign accept = in_valid && ready_q;

  // A byte decoded in IDLE registers its write here, so it appears the next cycle.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    inc_col = 1'b0;
    dec_col = 1'b0;
    cr      = 1'b0;
    newline = 1'b0;
    home    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sweep_d = '0;
          if (is_printable(in_data)) begin
            wr_en_d = 1'b1;
            waddr_d = cell_addr;
            wdata_d = in_data;
            if (at_last_col) begin
              cr      = 1'b1;
              newline = 1'b1;
              state_d = CLR_LINE;
            end else begin
              inc_col = 1'b1;
            end
          end else begin
            case (in_data)
              CH_CR: cr = 1'b1;
              CH_LF: begin
                cr      = 1'b1;
                newline = 1'b1;
                state_d = CLR_LINE;
              end
              CH_BS: begin
                if (!at_first_col) begin
                  dec_col = 1'b1;
                  wr_en_d = 1'b1;
                  waddr_d = cell_addr - ADDR_W'(1);
                  wdata_d = FILL;
                end
              end
              CH_FF: begin
                home    = 1'b1;
                state_d = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        wr_en_d = 1'b1;
        waddr_d = row_base + sweep_q;
        wdata_d = FILL;
        if (sweep_q == LAST_COL) begin
          sweep_d = '0;
          state_d = IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      CLR_ALL: begin
        wr_en_d = 1'b1;
        waddr_d = sweep_q;
        wdata_d = FILL;
        if (sweep_q == LAST_CELL) begin
          sweep_d = '0;
          state_d = IDLE;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: begin
        sweep_d = '0;
        state_d = CLR_ALL;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_ALL;
      sweep_q <= '0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      wr_en_q <= wr_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready    = ready_q;
  assign busy        = busy_q;
  assign vga_wr_en   = wr_en_q;
  assign vga_waddr   = waddr_q;
  assign vga_wdata   = wdata_q;
  assign cursor_addr = cell_addr;

endmodule

// File: tb/tb_vga_term_writer.sv
// Directed bench for vga_term_writer: a screen-level model predicts every
// write (address, data, cycle), in_ready/busy and the cursor each cycle.
module tb_vga_term_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
  localparam int FILL  = 32'h20;

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] vga_waddr;
  logic [7:0]  vga_wdata;
  logic        vga_wr_en;
  logic [13:0] cursor_addr;
  logic        busy;

  vga_term_writer dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .vga_waddr   (vga_waddr),
    .vga_wdata   (vga_wdata),
    .vga_wr_en   (vga_wr_en),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t expQ[$];
  int  cyc          = 0;
  int  oldCyc       = 0;
  int  readyAt      = 32'h7fffffff;
  bit  pendingStart = 1'b1;
  int  mCol         = 0;
  int  mRow         = 0;
  int  acceptCnt    = 0;
  int  lastAcceptCyc = 0;
  int  wrCount      = 0;
  int  lastWAddr    = -1;
  int  lastWData    = -1;
  int  firstWAddr   = -1;
  bit  firstSeen    = 1'b0;
  int  lowReadyCnt  = 0;
  int  nTests       = 0;
  int  nFail        = 0;

  task checkOutput(input string name, input int actual, input int expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void pushWrite(int addr, int data, int when);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = when;
    expQ.push_back(e);
  endfunction

  function automatic void pushClear(int base, int count, int firstCyc);
    for (int i = 0; i < count; i++) pushWrite(base + i, FILL, firstCyc + i);
  endfunction

  // Newline clears the new row; the sweep starts the cycle after the accept.
  function automatic void modelNewline(int n);
    mRow = (mRow + 1) % ROWS;
    pushClear(mRow * COLS, COLS, n + 1);
    readyAt = n + COLS;
  endfunction

  function automatic void modelAccept(int b, int n);
    if (b >= 32 && b <= 126) begin
      pushWrite(mRow * COLS + mCol, b, n);
      mCol++;
      if (mCol == COLS) begin
        mCol = 0;
        modelNewline(n);
      end
    end else if (b == 13) begin
      mCol = 0;
    end else if (b == 10) begin
      mCol = 0;
      modelNewline(n);
    end else if (b == 8) begin
      if (mCol > 0) begin
        mCol--;
        pushWrite(mRow * COLS + mCol, FILL, n);
      end
    end else if (b == 12) begin
      mCol = 0;
      mRow = 0;
      pushClear(0, CELLS, n + 1);
      readyAt = n + CELLS;
    end
  endfunction

  // Model advances on rising edges; outputs are compared on falling edges.
  initial forever begin
    @(posedge clk48 or negedge clk48 or negedge rst_n);
    if (!rst_n) begin
      expQ.delete();
      mCol         = 0;
      mRow         = 0;
      readyAt      = 32'h7fffffff;
      pendingStart = 1'b1;
      firstSeen    = 1'b0;
    end else if (clk48) begin
      oldCyc = cyc;
      cyc    = cyc + 1;
      if (pendingStart) begin
        pendingStart = 1'b0;
        pushClear(0, CELLS, cyc);
        readyAt = oldCyc + CELLS;
      end else if (in_valid && oldCyc >= readyAt) begin
        acceptCnt++;
        lastAcceptCyc = cyc;
        modelAccept(int'(in_data), cyc);
      end
    end else begin
      checkOutput("in_ready", int'(in_ready), (cyc >= readyAt) ? 1 : 0);
      checkOutput("busy", int'(busy), (cyc >= readyAt) ? 0 : 1);
      checkOutput("cursor_addr", int'(cursor_addr), mRow * COLS + mCol);
      if (in_ready === 1'b0) lowReadyCnt++;
      if (vga_wr_en === 1'b1) begin
        wrCount++;
        lastWAddr = int'(vga_waddr);
        lastWData = int'(vga_wdata);
        if (!firstSeen) begin
          firstSeen  = 1'b1;
          firstWAddr = int'(vga_waddr);
        end
      end
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        checkOutput("vga_wr_en", int'(vga_wr_en), 1);
        checkOutput("vga_waddr", int'(vga_waddr), expQ[0].addr);
        checkOutput("vga_wdata", int'(vga_wdata), expQ[0].data);
        void'(expQ.pop_front());
      end else begin
        checkOutput("vga_wr_en_quiet", int'(vga_wr_en), 0);
      end
    end
  end

  task applyStimulus(input logic [7:0] b);
    int start;
    int t;
    in_data  = b;
    in_valid = 1'b1;
    start    = acceptCnt;
    for (t = 0; t < 5000 && acceptCnt == start; t++) begin
      @(negedge clk48);
      #1;
    end
    checkOutput("accept_in_time", (acceptCnt != start) ? 1 : 0, 1);
  endtask

  task waitIdle(input int bound);
    int t;
    for (t = 0; t < bound; t++) begin
      if (cyc >= readyAt && expQ.size() == 0) break;
      @(negedge clk48);
      #1;
    end
    checkOutput("idle_in_time", (t < bound) ? 1 : 0, 1);
  endtask

  int snapWr;
  int snapLow;
  int ffCyc;
  int aCyc;

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk48);
    #1;

    // Outputs while reset is held
    checkOutput("rst_wr_en", int'(vga_wr_en), 0);
    checkOutput("rst_waddr", int'(vga_waddr), 0);
    checkOutput("rst_wdata", int'(vga_wdata), 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_busy", int'(busy), 1);
    checkOutput("rst_cursor", int'(cursor_addr), 0);

    #2 rst_n = 1'b1;
    snapWr = wrCount;
    waitIdle(3000);
    checkOutput("boot_sweep_count", wrCount - snapWr, 2400);
    checkOutput("boot_sweep_first", firstWAddr, 0);
    checkOutput("boot_sweep_last", lastWAddr, 2399);
    checkOutput("boot_sweep_data", lastWData, 8'h20);
    checkOutput("boot_ready", int'(in_ready), 1);
    checkOutput("boot_busy", int'(busy), 0);
    checkOutput("boot_cursor", int'(cursor_addr), 0);

    // "AB" back-to-back
    applyStimulus(8'h41);
    aCyc = lastAcceptCyc;
    applyStimulus(8'h42);
    in_valid = 1'b0;
    checkOutput("ab_back_to_back", lastAcceptCyc - aCyc, 1);
    checkOutput("ab_last_addr", lastWAddr, 1);
    checkOutput("ab_last_data", lastWData, 8'h42);
    checkOutput("ab_cursor", int'(cursor_addr), 2);

    // 80 printables from column 0 wrap onto row 1 and clear it
    applyStimulus(8'h0D);
    snapWr  = wrCount;
    snapLow = lowReadyCnt;
    for (int i = 0; i < COLS; i++) applyStimulus(8'h41);
    in_valid = 1'b0;
    waitIdle(500);
    checkOutput("wrap_write_count", wrCount - snapWr, 160);
    checkOutput("wrap_last_addr", lastWAddr, 159);
    checkOutput("wrap_last_data", lastWData, 8'h20);
    checkOutput("wrap_cursor", int'(cursor_addr), 80);
    checkOutput("wrap_ready_low", lowReadyCnt - snapLow, 80);

    // Control characters on row 1
    snapWr = wrCount;
    applyStimulus(8'h58);
    applyStimulus(8'h59);
    applyStimulus(8'h08);
    in_valid = 1'b0;
    checkOutput("bs_addr", lastWAddr, 81);
    checkOutput("bs_data", lastWData, 8'h20);
    checkOutput("bs_cursor", int'(cursor_addr), 81);
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    applyStimulus(8'h7F);
    applyStimulus(8'h1B);
    in_valid = 1'b0;
    repeat (3) @(negedge clk48);
    #1;
    checkOutput("ctrl_write_count", wrCount - snapWr, 3);
    checkOutput("ctrl_cursor", int'(cursor_addr), 80);

    // Form feed with a printable held during the clear
    applyStimulus(8'h0C);
    ffCyc = lastAcceptCyc;
    applyStimulus(8'h41);
    in_valid = 1'b0;
    checkOutput("ff_hold_cycles", lastAcceptCyc - ffCyc, 2401);
    checkOutput("ff_next_addr", lastWAddr, 0);
    checkOutput("ff_next_data", lastWData, 8'h41);
    checkOutput("ff_cursor", int'(cursor_addr), 1);

    // Bottom wrap: 29 line feeds reach the last row, the 30th wraps to row 0
    applyStimulus(8'h0D);
    for (int i = 0; i < ROWS - 1; i++) applyStimulus(8'h0A);
    in_valid = 1'b0;
    waitIdle(500);
    checkOutput("last_row_cursor", int'(cursor_addr), 2320);
    snapWr = wrCount;
    applyStimulus(8'h0A);
    in_valid = 1'b0;
    waitIdle(500);
    checkOutput("bottom_wrap_count", wrCount - snapWr, 80);
    checkOutput("bottom_wrap_last", lastWAddr, 79);
    checkOutput("bottom_wrap_cursor", int'(cursor_addr), 0);

    // Reset in the middle of a line clear
    applyStimulus(8'h0A);
    in_valid = 1'b0;
    repeat (10) @(negedge clk48);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", int'(vga_wr_en), 0);
    checkOutput("midrst_waddr", int'(vga_waddr), 0);
    checkOutput("midrst_wdata", int'(vga_wdata), 0);
    checkOutput("midrst_ready", int'(in_ready), 0);
    checkOutput("midrst_busy", int'(busy), 1);
    checkOutput("midrst_cursor", int'(cursor_addr), 0);
    @(negedge clk48);
    #2 rst_n = 1'b1;
    snapWr = wrCount;
    waitIdle(3000);
    checkOutput("midrst_first_addr", firstWAddr, 0);
    checkOutput("midrst_sweep_count", wrCount - snapWr, 2400);
    checkOutput("midrst_ready_after", int'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_term_writer.md
Name: vga_term_writer

Overview:
- Terminal-style controller that sequences the VGA text-buffer write port (vga_waddr/vga_wdata/vga_wr_en) from a byte stream, e.g. UART RX or keyboard echo.
- Keeps a text cursor, interprets a small set of control characters, and runs line-clear and screen-clear sweeps.
- Sits inside core between the character source (valid/ready) and the VGA write port. It is write-only and never reads back the buffer.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- ADDR_W, 14, VGA write address width; COLS*ROWS must be at most 2^ADDR_W.
- FILL, 8'h20, byte written by clear operations.

Ports:
- clk48  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  character byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted on the edge where in_valid&in_ready.
- vga_waddr  out  ADDR_W  text-buffer write address.
- vga_wdata  out  8  text-buffer write data.
- vga_wr_en  out  1  one write per cycle while high.
- cursor_addr  out  ADDR_W  current cursor cell (row_base+col), for cursor display.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- **Reset (async assert, sync deassert):**
  - vga_wr_en=0, vga_waddr=0, vga_wdata=0, in_ready=0, busy=1.
  - col=0, row=0, row_base=0, cursor_addr=0.
  - State = CLR_ALL, so the screen is cleared after every reset.
- **Addressing:**
  - Cell address = row_base + col.
  - row_base is a register stepped by +COLS and wrapped to 0; no multiplier.
  - All outputs are registered.
- **States:** IDLE, CLR_LINE, CLR_ALL.
  - Each accepted byte is decoded in IDLE.
  - A printable or backspace write is issued on the next cycle from IDLE registers; no separate WRITE state.
- **Handshake and latency:**
  - in_ready=1 only in IDLE.
  - A byte accepted at edge N produces at most one vga_wr_en pulse in cycle N+1.
  - in_ready stays high on consecutive cycles when no sweep is triggered, giving 1 char/cycle throughput.
- **Decode of accepted byte:**
  - 0x20–0x7E: write byte at current cell, then col+1. If col was COLS-1: col=0 and perform newline.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: col=0 and newline.
  - 0x08 BS:
    - If col>0: col-1, and write FILL at the new cell.
    - If col=0: no-op; no write, no wrap to the previous row.
  - 0x0C FF: col=0, row=0, row_base=0, enter CLR_ALL.
  - Any other byte: consumed, no effect.
- **Newline:**
  - row = (row==ROWS-1) ? 0 : row+1, with row_base following.
  - Then enter CLR_LINE on the new row.
- **CLR_LINE:**
  - Writes FILL to row_base+0 … row_base+COLS-1, one per cycle, COLS consecutive vga_wr_en cycles.
  - Returns to IDLE the cycle after the last write; in_ready rises in that same cycle.
- **CLR_ALL:**
  - Writes FILL to addresses 0 … COLS*ROWS-1, one per cycle.
  - Then IDLE with cursor at (0,0).
  - Sweep counter width is ADDR_W; the terminal compare is against COLS*ROWS-1.
- **Ordering:** a printable at col=COLS-1 writes its character in cycle N+1 first; CLR_LINE of the next row starts at N+2.
- **cursor_addr:** updates the cycle after the cursor changes; held constant during sweeps.
- **Reset mid-sweep:** aborts the sweep, zeroes the cursor, restarts CLR_ALL from address 0.
- **in_valid during busy:** ignored; data is not sampled while in_ready=0.

Decomposition:
- Shared package `term_pkg`:
  - state enum (IDLE, CLR_LINE, CLR_ALL).
  - char constants CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, CH_SP=8'h20, CH_DEL=8'h7F.
- One sub-module `term_cursor`:
  - Holds col/row/row_base.
  - Has inc_col, dec_col, cr, newline and home strobes, and outputs cell address plus an at_last_col flag.

Test Plan:
- **Reset sweep:**
  - Stimulus: release rst_n.
  - Response: exactly 2400 vga_wr_en cycles, addrs 0..2399, data 0x20; then in_ready=1, busy=0, cursor_addr=0.
- **Printable stream:**
  - Stimulus: send "AB" back-to-back with in_valid held.
  - Response: writes (0,0x41) and (1,0x42) on consecutive cycles; cursor_addr=2.
- **Line wrap:**
  - Stimulus: 80 bytes of 0x41.
  - Response: last write to addr 79; then 80 writes of 0x20 at addrs 80..159; cursor_addr=80; in_ready low for exactly those 80 cycles.
- **Control characters:**
  - Stimulus: "XY", then 0x08, then 0x0D.
  - Response: BS writes 0x20 to addr 1 with cursor=1; CR gives cursor=0 with no write; a second 0x08 at col 0 produces no write.
- **Bottom wrap:**
  - Stimulus: 29 LFs, then a 30th LF.
  - Response: the 30th LF clears addrs 0..79; cursor_addr=0.
- **Mid-sweep behaviour:**
  - Stimulus: send 0x0C, then hold in_valid with 0x41 during the clear.
  - Response: 0x41 is not consumed until the clear ends, then written to addr 0.
  - Stimulus: assert rst_n low mid-CLR_LINE.
  - Response: outputs zero immediately and a CLR_ALL restarts at addr 0.
